// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: control, data and status bundle between a FIFO and its user.
interface fifo_sync_flags_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
);
    logic                    EN;
    logic                    CLR;
    logic                    WR;
    logic                    RD;
    logic [DATA_WIDTH-1:0]   dataIn;
    logic [DATA_WIDTH-1:0]   dataOut;
    logic                    VALID;
    logic                    EMPTY;
    logic                    FULL;
    logic                    ALMOST_EMPTY;
    logic                    ALMOST_FULL;
    logic [$clog2(DEPTH):0]  Count;
    logic                    OVERFLOW;
    logic                    UNDERFLOW;

    modport master (
        output EN, CLR, WR, RD, dataIn,
        input  dataOut, VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, Count, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  EN, CLR, WR, RD, dataIn,
        output dataOut, VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, Count, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with registered count, threshold flags and
// selectable registered-read or first-word-fall-through output.
module fifo_sync_flags #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input logic                Clk,
    input logic                Rst_n,
    fifo_sync_flags_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, cnt, cnt_nxt, nrp;
    logic [DATA_WIDTH-1:0] dout, head_nxt;
    logic                  vld, ovf, unf, act, wr_ok, rd_ok, full, empty;

    always_comb begin
        act      = bus.EN & ~bus.CLR;
        full     = cnt == PW'(DEPTH);
        empty    = cnt == '0;
        wr_ok    = act & bus.WR & ~full;
        rd_ok    = act & bus.RD & ~empty;
        cnt_nxt  = cnt + PW'(wr_ok) - PW'(rd_ok);
        nrp      = rd_ptr + PW'(rd_ok);
        // the head after this edge may be the word being written right now
        head_nxt = (wr_ok && nrp == wr_ptr) ? bus.dataIn : mem[nrp[AW-1:0]];
    end

    always_ff @(posedge Clk)
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= bus.dataIn;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            vld    <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            ovf <= act & bus.WR & full;
            unf <= act & bus.RD & empty;
            vld <= rd_ok;
            if (act) begin
                wr_ptr <= wr_ptr + PW'(wr_ok);
                rd_ptr <= nrp;
                cnt    <= cnt_nxt;
            end else if (bus.EN) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end
            if (FWFT != 0 ? (act && cnt_nxt != '0) : rd_ok)
                dout <= FWFT != 0 ? head_nxt : mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus.dataOut      = dout;
    assign bus.VALID        = FWFT != 0 ? ~empty : vld;
    assign bus.EMPTY        = empty;
    assign bus.FULL         = full;
    assign bus.ALMOST_EMPTY = cnt <= PW'(AEMPTY_THRESH);
    assign bus.ALMOST_FULL  = cnt >= PW'(AFULL_THRESH);
    assign bus.Count        = cnt;
    assign bus.OVERFLOW     = ovf;
    assign bus.UNDERFLOW    = unf;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: registered-read and FWFT instances driven in lockstep,
// checked against a queue-based model plus a directed vector table.
module tb_fifo_sync_flags;
    logic Clk, Rst_n;
    int   nchk, nerr;

    fifo_sync_flags_if #(.DATA_WIDTH(32), .DEPTH(32)) b0 ();
    fifo_sync_flags_if #(.DATA_WIDTH(32), .DEPTH(32)) b1 ();

    fifo_sync_flags #(.DATA_WIDTH(32), .DEPTH(32), .FWFT(0)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(b0));
    fifo_sync_flags #(.DATA_WIDTH(32), .DEPTH(32), .FWFT(1)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(b1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] q[$];
    logic        m_ovf, m_unf, m_v0;
    logic [31:0] m_d0, m_d1;

    typedef struct {
        logic        en, clr, wr, rd;
        logic [31:0] din;
        int          cnt;
        logic        ovf, unf, v0;
        logic [31:0] d0;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_v0  = 1'b0;
        m_d0  = '0;
        m_d1  = '0;
    endtask

    task automatic model_edge(input logic en, clr, wr, rd, input logic [31:0] din);
        bit w, r;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_v0  = 1'b0;
        if (en && !clr) begin
            w     = wr && q.size() < 32;
            r     = rd && q.size() > 0;
            m_ovf = wr && q.size() == 32;
            m_unf = rd && q.size() == 0;
            if (r) begin
                m_d0 = q.pop_front();
                m_v0 = 1'b1;
            end
            if (w) q.push_back(din);
        end else if (en) q.delete();
        if (q.size() > 0) m_d1 = q[0];
    endtask

    task automatic mcheck();
        chk("count0",  64'(b0.Count), 64'(q.size()));
        chk("count1",  64'(b1.Count), 64'(q.size()));
        chk("empty",   64'(b0.EMPTY), 64'(q.size() == 0));
        chk("full",    64'(b0.FULL), 64'(q.size() == 32));
        chk("aempty",  64'(b0.ALMOST_EMPTY), 64'(q.size() <= 4));
        chk("afull",   64'(b0.ALMOST_FULL), 64'(q.size() >= 28));
        chk("ovf",     64'(b0.OVERFLOW), 64'(m_ovf));
        chk("unf",     64'(b0.UNDERFLOW), 64'(m_unf));
        chk("valid0",  64'(b0.VALID), 64'(m_v0));
        chk("dout0",   64'(b0.dataOut), 64'(m_d0));
        chk("valid1",  64'(b1.VALID), 64'(q.size() > 0));
        chk("dout1",   64'(b1.dataOut), 64'(m_d1));
    endtask

    task automatic step(input logic en, clr, wr, rd, input logic [31:0] din);
        b0.EN = en; b0.CLR = clr; b0.WR = wr; b0.RD = rd; b0.dataIn = din;
        b1.EN = en; b1.CLR = clr; b1.WR = wr; b1.RD = rd; b1.dataIn = din;
        @(posedge Clk);
        model_edge(en, clr, wr, rd, din);
        #1;
        mcheck();
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        model_reset();
        mcheck();
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 1, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  0, 1'b0, 1'b0, 1'b1, 32'h11};
        tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  0, 1'b0, 1'b1, 1'b0, 32'h11};
        tv[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 0, 1'b0, 1'b0, 1'b0, 32'h11};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 0, 1'b0, 1'b0, 1'b0, 32'h11};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 1, 1'b0, 1'b0, 1'b0, 32'h11};
        tv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1, 1'b0, 1'b0, 1'b1, 32'h22};
        tv[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1, 1'b0, 1'b0, 1'b0, 32'h22};
        b0.EN = 0; b0.CLR = 0; b0.WR = 0; b0.RD = 0; b0.dataIn = '0;
        b1.EN = 0; b1.CLR = 0; b1.WR = 0; b1.RD = 0; b1.dataIn = '0;
        Rst_n = 1'b0;
        model_reset();
        #12;
        mcheck();
        Rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(tv[i].en, tv[i].clr, tv[i].wr, tv[i].rd, tv[i].din);
            chk($sformatf("tv%0d_count", i), 64'(b0.Count), 64'(tv[i].cnt));
            chk($sformatf("tv%0d_ovf", i), 64'(b0.OVERFLOW), 64'(tv[i].ovf));
            chk($sformatf("tv%0d_unf", i), 64'(b0.UNDERFLOW), 64'(tv[i].unf));
            chk($sformatf("tv%0d_valid", i), 64'(b0.VALID), 64'(tv[i].v0));
            chk($sformatf("tv%0d_dout", i), 64'(b0.dataOut), 64'(tv[i].d0));
        end

        // fill to full, then one rejected write
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 1, 0, 32'(i));
            chk("afull_edge", 64'(b0.ALMOST_FULL), 64'(i + 1 >= 28));
        end
        chk("fill_full", 64'(b0.FULL), 64'd1);
        chk("fill_count", 64'(b0.Count), 64'd32);
        step(1, 0, 1, 0, 32'hDEAD);
        chk("overflow_pulse", 64'(b0.OVERFLOW), 64'd1);
        step(1, 0, 0, 0, 0);
        chk("overflow_drop", 64'(b0.OVERFLOW), 64'd0);

        // drain in order, then underflow
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 0, 1, 0);
            chk("drain_data", 64'(b0.dataOut), 64'(i));
        end
        step(1, 0, 0, 1, 0);
        chk("underflow_pulse", 64'(b0.UNDERFLOW), 64'd1);
        chk("underflow_empty", 64'(b0.EMPTY), 64'd1);

        // steady half-full streaming across pointer wrap
        for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 32'(i));
        for (int i = 16; i < 116; i++) step(1, 0, 1, 1, 32'(i));
        chk("stream_count", 64'(b0.Count), 64'd16);
        chk("stream_last", 64'(b0.dataOut), 64'd99);

        // FWFT fall-through into empty
        do_reset();
        step(1, 0, 1, 0, 32'hA5A5A5A5);
        chk("fwft_head", 64'(b1.dataOut), 64'hA5A5A5A5);
        chk("fwft_valid", 64'(b1.VALID), 64'd1);
        step(1, 0, 0, 1, 0);
        chk("fwft_empty", 64'(b1.EMPTY), 64'd1);
        chk("fwft_valid_off", 64'(b1.VALID), 64'd0);

        // flush with WR/RD asserted
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 32'(100 + i));
        step(1, 1, 1, 1, 32'hBEEF);
        chk("clr_count", 64'(b0.Count), 64'd0);
        chk("clr_empty", 64'(b0.EMPTY), 64'd1);

        // asynchronous reset mid-operation
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 32'(200 + i));
        Rst_n = 1'b0;
        #1;
        model_reset();
        mcheck();
        chk("arst_count", 64'(b0.Count), 64'd0);
        #1;
        Rst_n = 1'b1;
        step(1, 0, 1, 0, 32'd1);
        chk("arst_write", 64'(b0.Count), 64'd1);

        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2) != 0 ? 8 : 2;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) < bias, $urandom_range(0, 9) < (10 - bias), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set word width in bits.
REQ-002 Parameter DEPTH, default 32, SHALL set storage words; power of two, >= 4.
REQ-003 Parameter AFULL_THRESH, default DEPTH-4, SHALL set ALMOST_FULL level (1..DEPTH-1).
REQ-004 Parameter AEMPTY_THRESH, default 4, SHALL set ALMOST_EMPTY level (1..DEPTH-1).
REQ-005 Parameter FWFT, default 0, SHALL select mode: 0 registered-read, 1 first-word-fall-through.
REQ-006 Ports SHALL be, one clock; reset is asynchronous and active-low:
  Clk  in  1  clock, all state on rising edge
  Rst_n  in  1  asynchronous active-low reset
  EN  in  1  global enable; 0 blocks all accepts and flushes
  CLR  in  1  synchronous flush
  WR  in  1  write request
  RD  in  1  read request
  dataIn  in  DATA_WIDTH  write data
  dataOut  out  DATA_WIDTH  read data
  VALID  out  1  dataOut holds a valid word
  EMPTY  out  1  Count == 0
  FULL  out  1  Count == DEPTH
  ALMOST_EMPTY  out  1  Count <= AEMPTY_THRESH
  ALMOST_FULL  out  1  Count >= AFULL_THRESH
  Count  out  $clog2(DEPTH)+1  words stored
  OVERFLOW  out  1  one-cycle pulse: write rejected
  UNDERFLOW  out  1  one-cycle pulse: read rejected

Function
REQ-007 Write SHALL be accepted iff EN=1, CLR=0, WR=1, FULL=0; word stored at write pointer, pointer +1.
REQ-008 Read SHALL be accepted iff EN=1, CLR=0, RD=1, EMPTY=0; read pointer +1.
REQ-009 Pointers SHALL be $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; address = low $clog2(DEPTH) bits.
REQ-010 Count SHALL be registered, equal to (wr_ptr - rd_ptr) modulo 2*DEPTH, never exceeding DEPTH.
REQ-011 Simultaneous accepted read and write SHALL leave Count unchanged; both pointers advance.
REQ-012 When FULL, WR=1 SHALL be rejected even if a read is accepted in the same cycle.
REQ-013 EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL SHALL be decoded from registered Count only.
REQ-014 OVERFLOW SHALL pulse the cycle after EN=1, CLR=0, WR=1, FULL=1; else 0.
REQ-015 UNDERFLOW SHALL pulse the cycle after EN=1, CLR=0, RD=1, EMPTY=1; else 0.
REQ-016 FWFT=0: dataOut SHALL load the head word on the edge accepting a read; VALID=1 for that following cycle only; dataOut holds otherwise.
REQ-017 FWFT=1: dataOut SHALL present the head word whenever EMPTY=0, VALID = !EMPTY; a read pops the head and the next word appears after that edge.
REQ-018 FWFT=1: a word written into an empty FIFO at edge N SHALL be on dataOut with VALID=1 after edge N.
REQ-019 CLR=1 with EN=1 SHALL zero both pointers and Count, ignore RD/WR, clear VALID; dataOut holds.
REQ-020 EN=0 SHALL freeze pointers, Count, dataOut; VALID in FWFT=0 SHALL clear; no OVERFLOW/UNDERFLOW.
REQ-021 Memory contents SHALL NOT be reset or cleared; only pointers define occupancy.

Reset
REQ-022 Rst_n=0 SHALL immediately, without Clk, force pointers=0, Count=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, dataOut=0, VALID=0, OVERFLOW=0, UNDERFLOW=0.
REQ-023 Reset mid-operation SHALL discard all stored words; first edge after Rst_n rises SHALL behave as from empty.

Verification (DATA_WIDTH=32, DEPTH=32, thresholds default)
REQ-024 Write 0..31, then WR once more -> FULL=1, Count=32, ALMOST_FULL from Count=28, OVERFLOW one pulse, contents unchanged.
REQ-025 FWFT=0, read 32 words -> dataOut 0..31 in order, each one cycle after RD with VALID=1; 33rd RD -> UNDERFLOW pulse, EMPTY=1.
REQ-026 Fill 16, then 100 cycles WR=RD=1 with incrementing data -> Count stays 16, output sequence unbroken across pointer wrap.
REQ-027 FWFT=1, write 0xA5A5A5A5 into empty -> dataOut=0xA5A5A5A5, VALID=1 next cycle without RD; RD -> EMPTY=1, VALID=0.
REQ-028 Fill 10, assert CLR one cycle with WR=RD=1 -> Count=0, EMPTY=1, no write taken, no flags pulsed.
REQ-029 Fill 10, drop Rst_n between edges -> all outputs at reset values before next edge; then write 1 -> Count=1.
